// File: rtl/emu_run_ctrl.sv
// Run controller for the emulation time loop: owns the clk_sys gate enable and
// decides when emulated time runs, pauses, single-steps or terminates.
module emu_run_ctrl #(
    parameter int CNT_WIDTH  = 32,
    parameter int TIME_WIDTH = 64
) (
    input  logic                  clk_orig,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  pause_req,
    input  logic                  step_req,
    input  logic                  abort,
    input  logic [TIME_WIDTH-1:0] time_stop,
    input  logic [CNT_WIDTH-1:0]  run_limit,
    input  logic [TIME_WIDTH-1:0] time_curr,
    output logic                  clk_en,
    output logic                  busy,
    output logic                  paused,
    output logic                  sim_done,
    output logic [CNT_WIDTH-1:0]  step_count,
    output logic [1:0]            status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_STEP,
        S_DONE
    } state_t;

    localparam logic [1:0] ST_NONE   = 2'd0;
    localparam logic [1:0] ST_TIME   = 2'd1;
    localparam logic [1:0] ST_BUDGET = 2'd2;
    localparam logic [1:0] ST_ABORT  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // With an unlimited budget the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                      input logic               sat);
        if (sat && (&v)) begin
            return v;
        end
        return v + CNT_ONE;
    endfunction

    state_t                  r_state;
    logic                    r_clk_en;
    logic                    r_busy;
    logic                    r_paused;
    logic                    r_sim_done;
    logic [CNT_WIDTH-1:0]    r_step_count;
    logic [1:0]              r_status;
    logic [TIME_WIDTH-1:0]   r_stop_q;
    logic [CNT_WIDTH-1:0]    r_limit_q;

    state_t                  w_state_nxt;
    logic [1:0]              w_status_nxt;
    logic                    w_capture;
    logic                    w_time_hit;
    logic                    w_budget_hit;
    logic [CNT_WIDTH:0]      w_steps_after;

    // Steps completed once the current edge is taken; the budget check compares
    // against this so the run ends exactly on the last budgeted enabled cycle.
    assign w_steps_after = {1'b0, r_step_count} + {{CNT_WIDTH{1'b0}}, r_clk_en};
    assign w_time_hit    = (time_curr >= r_stop_q);
    assign w_budget_hit  = (r_limit_q != '0) && (w_steps_after == {1'b0, r_limit_q});

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_capture    = 1'b1;
                    w_status_nxt = ST_NONE;
                    w_state_nxt  = pause_req ? S_PAUSE : S_RUN;
                end
            end
            S_RUN, S_STEP: begin
                if (abort) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_ABORT;
                end else if (w_time_hit) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_TIME;
                end else if (w_budget_hit) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_BUDGET;
                end else if ((r_state == S_STEP) || pause_req) begin
                    w_state_nxt  = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_ABORT;
                end else if (w_time_hit) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_TIME;
                end else if (step_req) begin
                    w_state_nxt  = S_STEP;
                end else if (!pause_req) begin
                    w_state_nxt  = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Every output is registered from the next state so clk_en changes on the
    // same edge as the decision, never a cycle later.
    always_ff @(posedge clk_orig or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_clk_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_paused     <= 1'b0;
            r_sim_done   <= 1'b0;
            r_step_count <= '0;
            r_status     <= ST_NONE;
            r_stop_q     <= '0;
            r_limit_q    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_en   <= (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP);
            r_busy     <= (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE) ||
                          (w_state_nxt == S_STEP);
            r_paused   <= (w_state_nxt == S_PAUSE);
            r_sim_done <= (w_state_nxt == S_DONE);
            r_status   <= w_status_nxt;
            if (w_capture) begin
                r_stop_q  <= time_stop;
                r_limit_q <= run_limit;
            end
            if (w_capture) begin
                r_step_count <= '0;
            end else if (r_clk_en) begin
                r_step_count <= sat_inc(r_step_count, r_limit_q == '0);
            end
        end
    end

    assign clk_en     = r_clk_en;
    assign busy       = r_busy;
    assign paused     = r_paused;
    assign sim_done   = r_sim_done;
    assign step_count = r_step_count;
    assign status     = r_status;

endmodule

// File: tb/tb_emu_run_ctrl.sv
// Bench for emu_run_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against a mode-level behavioural model of the run controller.
`timescale 1ns/1ps
module tb_emu_run_ctrl;

    localparam int CW = 8;
    localparam int TW = 32;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_STEP  = 3;
    localparam int M_DONE  = 4;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [TW-1:0] T_MAX   = '1;

    logic          clk_orig  = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          pause_req = 1'b0;
    logic          step_req  = 1'b0;
    logic          abort     = 1'b0;
    logic [TW-1:0] time_stop = '0;
    logic [TW-1:0] time_curr = '0;
    logic [CW-1:0] run_limit = '0;
    logic          clk_en;
    logic          busy;
    logic          paused;
    logic          sim_done;
    logic [CW-1:0] step_count;
    logic [1:0]    status;

    int n_tests = 0;
    int n_fail  = 0;
    bit ramp    = 1'b0;
    int n_en    = 0;

    emu_run_ctrl #(.CNT_WIDTH(CW), .TIME_WIDTH(TW)) dut (
        .clk_orig  (clk_orig),
        .rst_n     (rst_n),
        .start     (start),
        .pause_req (pause_req),
        .step_req  (step_req),
        .abort     (abort),
        .time_stop (time_stop),
        .run_limit (run_limit),
        .time_curr (time_curr),
        .clk_en    (clk_en),
        .busy      (busy),
        .paused    (paused),
        .sim_done  (sim_done),
        .step_count(step_count),
        .status    (status)
    );

    initial forever #5 clk_orig = ~clk_orig;

    // ---------------- behavioural model ----------------
    int            m_mode   = M_IDLE;
    logic [CW-1:0] m_cnt    = '0;
    logic [1:0]    m_status = 2'd0;
    logic [TW-1:0] m_stop   = '0;
    logic [CW-1:0] m_limit  = '0;
    logic          m_adv    = 1'b0;
    logic          m_en;
    int            m_after;
    logic [1:0]    m_cause;

    function automatic logic [1:0] end_cause(input int md, input logic ab,
                                             input logic [TW-1:0] tc, input logic [TW-1:0] stp,
                                             input logic [CW-1:0] lim, input int after);
        if (!(md == M_RUN || md == M_PAUSE || md == M_STEP)) return 2'd0;
        if (ab) return 2'd3;
        if (tc >= stp) return 2'd1;
        if (lim != '0 && after == int'(lim)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic int resume_mode(input int md, input logic pr, input logic sr);
        case (md)
            M_RUN:   return pr ? M_PAUSE : M_RUN;
            M_STEP:  return M_PAUSE;
            M_PAUSE: return sr ? M_STEP : (pr ? M_PAUSE : M_RUN);
            default: return md;
        endcase
    endfunction

    assign m_en    = (m_mode == M_RUN) || (m_mode == M_STEP);
    assign m_after = int'(m_cnt) + (m_en ? 1 : 0);
    assign m_cause = end_cause(m_mode, abort, time_curr, m_stop, m_limit, m_after);

    always @(posedge clk_orig or negedge rst_n) begin
        if (!rst_n) begin
            m_mode   <= M_IDLE;
            m_cnt    <= '0;
            m_status <= 2'd0;
            m_stop   <= '0;
            m_limit  <= '0;
            m_adv    <= 1'b0;
        end else begin
            m_adv <= m_en;
            if (m_en && !(m_limit == '0 && m_cnt == CNT_MAX)) m_cnt <= m_cnt + CW'(1);
            if (m_mode == M_IDLE || m_mode == M_DONE) begin
                if (start) begin
                    m_stop   <= time_stop;
                    m_limit  <= run_limit;
                    m_cnt    <= '0;
                    m_status <= 2'd0;
                    m_mode   <= pause_req ? M_PAUSE : M_RUN;
                end
            end else if (m_cause != 2'd0) begin
                m_mode   <= M_DONE;
                m_status <= m_cause;
            end else begin
                m_mode <= resume_mode(m_mode, pause_req, step_req);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic e_busy;
        @(negedge clk_orig);
        e_busy = (m_mode == M_RUN) || (m_mode == M_PAUSE) || (m_mode == M_STEP);
        n_tests++;
        if (clk_en !== m_en || busy !== e_busy || paused !== (m_mode == M_PAUSE) ||
            sim_done !== (m_mode == M_DONE) || step_count !== m_cnt || status !== m_status) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t en/busy/paused/done/cnt/status got %b/%b/%b/%b/%0d/%0d want %b/%b/%b/%b/%0d/%0d",
                     $time, clk_en, busy, paused, sim_done, step_count, status,
                     m_en, e_busy, (m_mode == M_PAUSE), (m_mode == M_DONE), m_cnt, m_status);
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_orig);
        start    = 1'b0;
        step_req = 1'b0;
        abort    = 1'b0;
        if (ramp && m_adv) time_curr = time_curr + TW'(5);
    endtask

    task automatic go(input logic [CW-1:0] lim, input logic [TW-1:0] stp);
        run_limit = lim;
        time_stop = stp;
        start     = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_clk_en", clk_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_paused", paused, 0);
        chk("rst_sim_done", sim_done, 0);
        chk("rst_step_count", step_count, 0);
        chk("rst_status", status, 0);
        tick();
        rst_n = 1'b1;

        go(10, T_MAX);
        repeat (20) begin
            tick();
            if (clk_en) n_en++;
        end
        chk("budget_enabled_cycles", n_en, 10);
        chk("budget_step_count", step_count, 10);
        chk("budget_status", status, 2);
        chk("budget_done", sim_done, 1);

        time_curr = '0;
        ramp = 1'b1;
        go(0, 50);
        repeat (20) tick();
        chk("tstop_status", status, 1);
        chk("tstop_step_count", step_count, 11);
        chk("tstop_clk_en", clk_en, 0);
        ramp = 1'b0;
        time_curr = '0;

        go(0, T_MAX);
        repeat (3) tick();
        pause_req = 1'b1;
        repeat (4) tick();
        chk("pause_paused", paused, 1);
        chk("pause_frozen_count", step_count, 3);
        chk("pause_clk_en", clk_en, 0);
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            tick();
            chk("step_clk_en", clk_en, 1);
            chk("step_paused_low", paused, 0);
            tick();
            tick();
        end
        chk("step_count_plus3", step_count, 6);
        chk("step_back_paused", paused, 1);
        pause_req = 1'b0;
        tick();
        chk("resume_clk_en", clk_en, 1);
        chk("resume_paused", paused, 0);
        abort = 1'b1;
        tick();
        chk("abort_status", status, 3);

        go(0, 100);
        tick();
        tick();
        time_curr = 100;
        abort = 1'b1;
        tick();
        chk("abort_vs_time_status", status, 3);
        time_curr = '0;

        go(5, T_MAX);
        repeat (5) tick();
        pause_req = 1'b1;
        tick();
        chk("budget_vs_pause_status", status, 2);
        chk("budget_vs_pause_count", step_count, 5);
        chk("budget_vs_pause_done", sim_done, 1);
        pause_req = 1'b0;

        go(4, T_MAX);
        tick();
        chk("restart_count_clear", step_count, 0);
        chk("restart_status_clear", status, 0);
        chk("restart_busy", busy, 1);
        repeat (8) tick();
        chk("restart_count", step_count, 4);
        chk("restart_status", status, 2);

        go(0, T_MAX);
        repeat (270) tick();
        chk("sat_count", step_count, 255);
        chk("sat_clk_en", clk_en, 1);
        abort = 1'b1;
        tick();
        step_req = 1'b1;
        abort = 1'b1;
        tick();
        chk("done_ignores_abort", status, 3);
        chk("done_ignores_step", sim_done, 1);

        go(0, T_MAX);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_clk_en", clk_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_step_count", step_count, 0);
        chk("arst_status", status, 0);
        tick();
        tick();
        rst_n = 1'b1;
        go(3, T_MAX);
        repeat (6) tick();
        chk("post_arst_count", step_count, 3);
        chk("post_arst_status", status, 2);

        ramp = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (($urandom % 8) == 0) pause_req = ~pause_req;
            if (($urandom % 4) == 0) step_req = 1'b1;
            if (($urandom % 50) == 0) abort = 1'b1;
            if (($urandom % 12) == 0) begin
                start     = 1'b1;
                run_limit = CW'($urandom_range(0, 15));
                time_stop = (($urandom % 8) == 0) ? T_MAX : TW'($urandom_range(0, 90));
                if (m_mode == M_IDLE || m_mode == M_DONE) time_curr = '0;
            end
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
